r_type_exec_ctrl: RTL and testbench
===================================

Name: r_type_exec_ctrl

Overview:
Multi-cycle sequencer for the R-type execution path of the RISC-V core. It fetches instruction words over a valid/ready-style memory handshake and decodes rs1/rs2/rd and the ALU select. It then drives register-file read, ALU start/done and register-file writeback in order, advancing the PC by 4 per retired or rejected instruction. It sits between instruction memory, the register file and the ALU. Non-R-type or malformed words are flagged and skipped.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ALU_TIMEOUT, 16, max cycles EXEC waits for alu_done before aborting (>=2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
enable  in  1  run request; sampled in IDLE and at end of each instruction
imem_req  out  1  fetch request, held high in FETCH until imem_valid
imem_addr  out  32  fetch address (= pc)
imem_valid  in  1  imem_rdata valid this cycle
imem_rdata  in  32  instruction word
rs1  out  5  IR[19:15], registered
rs2  out  5  IR[24:20], registered
rd  out  5  IR[11:7], registered
alu_sel  out  4  {IR[30], IR[14:12]}
rf_rd_en  out  1  register-file read strobe
alu_start  out  1  one-cycle ALU start pulse
alu_done  in  1  ALU result ready
rf_wr_en  out  1  register-file write strobe
illegal_inst  out  1  one-cycle pulse: rejected instruction
alu_timeout  out  1  sticky error: ALU did not respond
pc  out  32  current PC
retired  out  CNT_W  count of written-back instructions, wraps

Behaviour:
- All outputs registered. Reset (reset_n=0 at a clk edge): state=IDLE, pc=RESET_PC, IR=0, retired=0, all strobes/flags 0, rs1/rs2/rd/alu_sel=0.
- Reset mid-operation: abort immediately to IDLE. Late imem_valid/alu_done are ignored.
- States: IDLE, FETCH, DECODE, READ, EXEC, WB, HALT.
- IDLE: all strobes 0. enable=1 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_valid=1, latch imem_rdata into IR -> DECODE. Otherwise stay; no timeout on fetch.
- DECODE (1 cycle): load rs1/rs2/rd/alu_sel from IR. A word is legal iff opcode=0110011 and either funct7=0000000, or funct7=0100000 with funct3 in {000,101}. Legal -> READ.
- Illegal: illegal_inst=1 for one cycle, pc+=4, no rf/ALU strobes. Go to FETCH if enable=1, else IDLE.
- READ: rf_rd_en=1 for exactly one cycle -> EXEC.
- EXEC: alu_start=1 in the first EXEC cycle only. alu_done is ignored in that first cycle. alu_done=1 in any later cycle -> WB.
- EXEC wait counter starts at the alu_start cycle. If ALU_TIMEOUT cycles elapse without alu_done: set alu_timeout (sticky), go to HALT.
- HALT: all strobes 0, pc held. Only reset exits HALT.
- WB (1 cycle): rf_wr_en=1 unless rd==0 (write suppressed). retired+=1 regardless, wraps at 2^CNT_W. pc+=4, 32-bit wrap from FFFF_FFFC to 0000_0000. Then FETCH if enable=1, else IDLE.
- enable deasserted mid-instruction: the current instruction completes, then IDLE.
- Minimum latency per legal instruction: 6 cycles (FETCH 1, DECODE 1, READ 1, EXEC 2, WB 1). Back-to-back when enable is held.
- rs1/rs2/rd/alu_sel hold their values from DECODE until the next DECODE.

Test Plan:
- Reset, enable=1, imem returns 0x004A82B3 same cycle, alu_done 1 cycle after start -> rs1=21, rs2=4, rd=5, alu_sel=4'b0000. rf_rd_en, alu_start, rf_wr_en each one cycle. pc 0->4, retired=1, six cycles total.
- Fetch 0x405A8333 with imem_valid delayed 3 cycles -> imem_req held 4 cycles, imem_addr=pc. rs1=21, rs2=5, rd=6, alu_sel=4'b1000.
- Fetch 0x00000013 (ADDI), then 0x4004A2B3 (funct7=0100000, funct3=010) -> illegal_inst pulses once for each, no rf/ALU strobes, pc advances by 4 each, retired unchanged.
- R-type with rd=0 (0x004A8033) -> rf_wr_en stays 0, retired increments, pc+=4.
- alu_done never asserted with ALU_TIMEOUT=16 -> alu_timeout=1 after 16 cycles, state HALT, all strobes 0. reset_n=0 clears it, pc=RESET_PC.
- reset_n=0 during EXEC with alu_done arriving on the next cycle -> IDLE, no rf_wr_en, retired=0. Separately, drop enable during READ -> instruction retires, then IDLE with imem_req=0.

Source files
------------

// File: rtl/r_type_exec_ctrl.sv
// r_type_exec_ctrl: multi-cycle fetch/decode/read/exec/writeback sequencer for R-type ops.
// Rev 1.0 - initial release.
`default_nettype none

module r_type_exec_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ALU_TIMEOUT = 16,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [3:0]       alu_sel,
    output logic             rf_rd_en,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             rf_wr_en,
    output logic             illegal_inst,
    output logic             alu_timeout,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TIMEOUT);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t        state;
    logic [31:0]   ir;
    logic [TW-1:0] wait_cnt;
    logic          legal;

    assign legal = (ir[6:0] == 7'b0110011) &&
                   ((ir[31:25] == 7'b0000000) ||
                    ((ir[31:25] == 7'b0100000) &&
                     ((ir[14:12] == 3'b000) || (ir[14:12] == 3'b101))));

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            ir           <= '0;
            retired      <= '0;
            wait_cnt     <= '0;
            rs1          <= '0;
            rs2          <= '0;
            rd           <= '0;
            alu_sel      <= '0;
            imem_req     <= 1'b0;
            rf_rd_en     <= 1'b0;
            alu_start    <= 1'b0;
            rf_wr_en     <= 1'b0;
            illegal_inst <= 1'b0;
            alu_timeout  <= 1'b0;
        end else begin
            // Strobes default low; each state re-asserts only what it owns.
            imem_req     <= 1'b0;
            rf_rd_en     <= 1'b0;
            alu_start    <= 1'b0;
            rf_wr_en     <= 1'b0;
            illegal_inst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    rs1     <= ir[19:15];
                    rs2     <= ir[24:20];
                    rd      <= ir[11:7];
                    alu_sel <= {ir[30], ir[14:12]};
                    if (legal) begin
                        state    <= S_READ;
                        rf_rd_en <= 1'b1;
                    end else begin
                        illegal_inst <= 1'b1;
                        pc           <= pc + 32'd4;
                        if (enable) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_READ: begin
                    state     <= S_EXEC;
                    alu_start <= 1'b1;
                    wait_cnt  <= CNT_ONE;
                end
                S_EXEC: begin
                    // wait_cnt==1 is the alu_start cycle, where alu_done is not trusted.
                    if ((wait_cnt != CNT_ONE) && alu_done) begin
                        state    <= S_WB;
                        rf_wr_en <= (rd != 5'd0);
                    end else if (wait_cnt == TMO_LAST) begin
                        alu_timeout <= 1'b1;
                        state       <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                S_WB: begin
                    retired <= retired + CNT_W'(1);
                    pc      <= pc + 32'd4;
                    if (enable) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_r_type_exec_ctrl.sv
// tb_r_type_exec_ctrl: directed plus randomized instruction stream against a per-instruction model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_r_type_exec_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_valid = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic [4:0]    rs1, rs2, rd;
    logic [3:0]    alu_sel;
    logic          rf_rd_en, alu_start, rf_wr_en;
    logic          alu_done = 1'b0;
    logic          illegal_inst, alu_timeout;
    logic [31:0]   pc;
    logic [CW-1:0] retired;

    r_type_exec_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .ALU_TIMEOUT (16),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .alu_sel      (alu_sel),
        .rf_rd_en     (rf_rd_en),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .rf_wr_en     (rf_wr_en),
        .illegal_inst (illegal_inst),
        .alu_timeout  (alu_timeout),
        .pc           (pc),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc   = 32'h0;
    int          m_ret  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        return (w[6:0] == 7'h33) && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    endfunction

    // mode 0: normal completion, 1: ALU never answers, 2: reset asserted in first EXEC cycle.
    // Entry: at a negedge with the DUT in FETCH.
    task automatic do_instr(input logic [31:0] w, input int fdly, input int ddly,
                            input bit keep_en, input int mode);
        bit lg;
        lg = is_legal(w);
        enable = 1'b1;
        for (int k = 0; k <= fdly; k++) begin
            chk("imem_req_fetch", imem_req, 1);
            chk("imem_addr", imem_addr, m_pc);
            imem_valid = (k == fdly);
            imem_rdata = (k == fdly) ? w : $urandom;
            @(negedge clk);
        end
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        chk("imem_req_decode", imem_req, 0);
        chk("rf_rd_en_decode", rf_rd_en, 0);
        if (!lg) enable = keep_en;
        @(negedge clk);
        chk("rs1", rs1, w[19:15]);
        chk("rs2", rs2, w[24:20]);
        chk("rd", rd, w[11:7]);
        chk("alu_sel", alu_sel, {w[30], w[14:12]});
        chk("illegal_inst", illegal_inst, !lg);
        chk("rf_rd_en", rf_rd_en, lg);
        if (!lg) begin
            m_pc = m_pc + 32'd4;
            chk("pc_illegal", pc, m_pc);
            chk("retired_illegal", retired, m_ret);
            chk("imem_req_after_illegal", imem_req, keep_en);
            return;
        end
        enable = keep_en;
        @(negedge clk);
        chk("alu_start", alu_start, 1);
        chk("rf_rd_en_exec", rf_rd_en, 0);
        if (mode == 2) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n  = 1'b1;
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
            m_pc  = 32'h0;
            m_ret = 0;
            chk("rf_wr_en_after_reset", rf_wr_en, 0);
            chk("retired_after_reset", retired, 0);
            chk("pc_after_reset", pc, 0);
            chk("imem_req_after_reset", imem_req, 0);
            return;
        end
        if (mode == 1) begin
            alu_done = 1'b0;
            for (int j = 0; j < 15; j++) begin
                @(negedge clk);
                chk("alu_timeout_early", alu_timeout, 0);
            end
            @(negedge clk);
            chk("alu_timeout_set", alu_timeout, 1);
            imem_valid = 1'b1;
            alu_done   = 1'b1;
            repeat (4) @(negedge clk);
            imem_valid = 1'b0;
            alu_done   = 1'b0;
            chk("halt_sticky", alu_timeout, 1);
            chk("halt_strobes", {imem_req, rf_rd_en, alu_start, rf_wr_en, illegal_inst}, 0);
            chk("halt_pc", pc, m_pc);
            return;
        end
        // Noise in the first EXEC cycle must not complete the instruction.
        alu_done = $urandom_range(0, 1);
        @(negedge clk);
        for (int j = 0; j <= ddly; j++) begin
            chk("alu_start_once", alu_start, 0);
            chk("rf_wr_en_early", rf_wr_en, 0);
            alu_done = (j == ddly);
            @(negedge clk);
        end
        alu_done = 1'b0;
        chk("rf_wr_en", rf_wr_en, w[11:7] != 5'd0);
        chk("retired_before_wb", retired, m_ret);
        @(negedge clk);
        m_pc  = m_pc + 32'd4;
        m_ret = (m_ret + 1) % (1 << CW);
        chk("pc_wb", pc, m_pc);
        chk("retired_wb", retired, m_ret);
        chk("rf_wr_en_pulse", rf_wr_en, 0);
        chk("imem_req_after_wb", imem_req, keep_en);
    endtask

    // Entry: DUT idle. Exit: DUT in FETCH at a negedge.
    task automatic restart();
        @(negedge clk);
        chk("idle_imem_req", imem_req, 0);
        chk("idle_strobes", {rf_rd_en, alu_start, rf_wr_en, illegal_inst}, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("fetch_entry", imem_req, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_pc  = 32'h0;
        m_ret = 0;
    endtask

    initial begin
        logic [31:0] w;
        bit          ke;

        do_reset();
        chk("reset_pc", pc, 0);
        chk("reset_retired", retired, 0);
        chk("reset_fields", {rs1, rs2, rd, alu_sel}, 0);
        chk("reset_strobes", {imem_req, rf_rd_en, alu_start, rf_wr_en, illegal_inst, alu_timeout}, 0);

        restart();
        do_instr(32'h004A82B3, 0, 0, 1'b1, 0);
        do_instr(32'h405A8333, 3, 2, 1'b1, 0);
        do_instr(32'h00000013, 0, 0, 1'b1, 0);
        do_instr(32'h4004A2B3, 1, 0, 1'b1, 0);
        do_instr(32'h004A8033, 0, 1, 1'b0, 0);
        restart();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom;
                w[6:0] = 7'h33;
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: w[31:25] = 7'($urandom);
                endcase
            end else begin
                w = $urandom;
            end
            ke = ($urandom_range(0, 3) != 0);
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 5), ke, 0);
            if (!ke) restart();
        end

        do_instr(32'h005303B3, 0, 0, 1'b1, 1);
        do_reset();
        chk("timeout_cleared", alu_timeout, 0);
        chk("pc_after_halt_reset", pc, 0);

        restart();
        do_instr(32'h00B50633, 1, 0, 1'b0, 2);
        restart();
        do_instr(32'h40B55633, 0, 3, 1'b0, 0);
        @(negedge clk);
        chk("idle_after_drop", imem_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
